shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 114 +++++++++++
 tb/tb_shift_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle 16-bit shifter: one 1-bit shift per clock through a single shared stage.
// Optional macro SHIFT_ARITH_EN enables sign-extending right shifts when arith=1.
module shift_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] data_in,
  input  logic [3:0]  amount,
  input  logic        dir,
  input  logic        arith,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] work_q, work_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic        fill;
  logic [15:0] stage_out;

`ifdef SHIFT_ARITH_EN
  logic arith_q, arith_d;

  assign fill = dir_q & arith_q & work_q[15];
`else
  logic unused_arith;

  assign unused_arith = arith;
  assign fill         = 1'b0;
`endif

  // The single shared 1-bit shift stage.
  assign stage_out = dir_q ? {fill, work_q[15:1]} : {work_q[14:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= 16'h0000;
      result_q <= 16'h0000;
      cnt_q    <= 4'd0;
      dir_q    <= 1'b0;
`ifdef SHIFT_ARITH_EN
      arith_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
`ifdef SHIFT_ARITH_EN
      arith_q  <= arith_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
`ifdef SHIFT_ARITH_EN
    arith_d  = arith_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = data_in;
          cnt_d  = amount;
          dir_d  = dir;
`ifdef SHIFT_ARITH_EN
          arith_d = arith;
`endif
          if (amount == 4'd0) begin
            state_d  = DONE;
            result_d = data_in;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d = stage_out;
        cnt_d  = cnt_q - 4'd1;
        // Result is captured on the same edge that performs the last shift.
        if (cnt_q == 4'd1) begin
          state_d  = DONE;
          result_d = stage_out;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus randomized operations
// compared against an arithmetic shift model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] data_in;
  logic [3:0]  amount;
  logic        dir;
  logic        arith;
  logic        busy;
  logic        done;
  logic [15:0] result;

  int          vectors    = 0;
  int          miscompares = 0;
  logic [15:0] prev_result = 16'h0000;

  logic [15:0] n_data;
  logic [3:0]  n_amt;
  logic        n_dir;
  logic        n_arith;

  shift_sequencer dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .amount  (amount),
    .dir     (dir),
    .arith   (arith),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a,
                                            input logic dr, input logic ar);
    logic signed [15:0] sd;
    sd = d;
    if (!dr) return d << a;
`ifdef SHIFT_ARITH_EN
    if (ar) return 16'(sd >>> a);
`else
    if (ar && sd[15]) return d >> a;
`endif
    return d >> a;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one operation starting at a negedge with the DUT idle. Inputs are scrambled
  // while busy (including a start pulse) to show they are ignored. With chain=1 the
  // next operation's start is raised during DONE and held into IDLE.
  task automatic run_op(input logic [15:0] d, input logic [3:0] a, input logic dr,
                        input logic ar, input bit chain);
    logic [15:0] exp;
    int          n;
    exp     = ref_shift(d, a, dr, ar);
    n       = int'(a) + 1;
    data_in = d;
    amount  = a;
    dir     = dr;
    arith   = ar;
    start   = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      chk("busy_in_flight", {15'd0, busy}, 16'd1);
      chk("done_timing", {15'd0, done}, {15'd0, (i == n)});
      chk("result_value", result, (i == n) ? exp : prev_result);
      if (i == n && chain) begin
        start   = 1'b1;
        data_in = n_data;
        amount  = n_amt;
        dir     = n_dir;
        arith   = n_arith;
      end else begin
        start   = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        data_in = (i == 1) ? 16'h1234 : 16'($urandom);
        amount  = 4'($urandom);
        dir     = 1'($urandom);
        arith   = 1'($urandom);
      end
    end
    @(negedge clk);
    chk("busy_after_done", {15'd0, busy}, 16'd0);
    chk("done_after_done", {15'd0, done}, 16'd0);
    chk("result_held", result, exp);
    if (!chain) start = 1'b0;
    prev_result = exp;
    $display("op data=%h amt=%0d dir=%0d arith=%0d chain=%0d -> result=%h expected=%h",
             d, a, dr, ar, chain, result, exp);
  endtask

  initial begin
    logic [15:0] c_data;
    logic [3:0]  c_amt;
    logic        c_dir;
    logic        c_arith;

    reset   = 1'b1;
    start   = 1'b0;
    data_in = 16'h0000;
    amount  = 4'd0;
    dir     = 1'b0;
    arith   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);
    chk("reset_result", result, 16'h0000);
    reset = 1'b0;

    run_op(16'h0001, 4'd4, 1'b0, 1'b0, 1'b0);
    chk("left_4", result, 16'h0010);
    run_op(16'hBEEF, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("zero_amount", result, 16'hBEEF);
    run_op(16'h8000, 4'd15, 1'b1, 1'b0, 1'b0);
    chk("right_logical_15", result, 16'h0001);
    run_op(16'h8000, 4'd15, 1'b1, 1'b1, 1'b0);
`ifdef SHIFT_ARITH_EN
    chk("right_arith_15", result, 16'hFFFF);
`else
    chk("right_arith_15", result, 16'h0001);
`endif
    run_op(16'h00F0, 4'd3, 1'b0, 1'b0, 1'b0);
    chk("busy_ignore", result, 16'h0780);

    // Hold: inputs wander with start low for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      data_in = 16'($urandom);
      amount  = 4'($urandom);
      dir     = 1'($urandom);
      @(negedge clk);
      chk("hold_result", result, prev_result);
      chk("hold_busy", {15'd0, busy}, 16'd0);
    end

    // Reset in the middle of an amount=8 operation.
    data_in = 16'hA5A5;
    amount  = 4'd8;
    dir     = 1'b0;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_done", {15'd0, done}, 16'd0);
    chk("abort_result", result, 16'h0000);
    @(negedge clk);
    chk("abort_hold_done", {15'd0, done}, 16'd0);
    reset       = 1'b0;
    prev_result = 16'h0000;
    run_op(16'h0003, 4'd1, 1'b0, 1'b0, 1'b0);
    chk("post_reset_left", result, 16'h0006);

    // Randomized operations, some chained back-to-back through DONE.
    c_data  = 16'($urandom);
    c_amt   = 4'($urandom);
    c_dir   = 1'($urandom);
    c_arith = 1'($urandom);
    for (int k = 0; k < 40; k++) begin
      bit chain;
      n_data  = 16'($urandom);
      n_amt   = (k % 7 == 0) ? 4'd15 : 4'($urandom);
      n_dir   = 1'($urandom);
      n_arith = 1'($urandom);
      chain   = (k != 39) && ($urandom_range(0, 2) == 0);
      run_op(c_data, c_amt, c_dir, c_arith, chain);
      c_data  = n_data;
      c_amt   = n_amt;
      c_dir   = n_dir;
      c_arith = n_arith;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
